// File: rtl/mem_bus_responder_if.sv
// Memory bus between the controlpath (MAR/MDR/RE/WE) and the memory-side responder.
`timescale 1ns/1ps

interface mem_bus_responder_if;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        re;
    logic        we;
    logic [15:0] rdata;

    // Controlpath side: drives the address, the write data and the strobes.
    modport master (output addr, output wdata, output re, output we, input rdata);

    // Memory side: decodes the cycle and returns read data combinationally.
    modport slave (input addr, input wdata, input re, input we, output rdata);
endinterface

// File: rtl/mem_bus_responder.sv
// Memory-side responder for the p18240 bus. It serves a word-addressed RAM at
// 0..RAM_WORDS-1 and an 8-word I/O page at IO_BASE holding LED, synchronized
// switches, a free-running counter, status and a receive FIFO.
`timescale 1ns/1ps

module mem_bus_responder #(
    parameter int          RAM_WORDS  = 1024,
    parameter logic [15:0] IO_BASE    = 16'hFF00,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                clock,
    input  logic                reset_L,
    mem_bus_responder_if.slave  bus,
    output logic [15:0]         led_out,
    input  logic [15:0]         sw_in,
    input  logic [15:0]         rx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    output logic                bus_err
);

    localparam int          RAM_AW    = $clog2(RAM_WORDS);
    localparam int          FIFO_AW   = $clog2(FIFO_DEPTH);
    localparam logic [16:0] RAM_LIMIT = 17'(RAM_WORDS);

    // Word offsets inside the I/O page; offsets 5..7 are unmapped.
    typedef enum logic [2:0] {
        IO_LED    = 3'd0,
        IO_SW     = 3'd1,
        IO_CNT    = 3'd2,
        IO_STATUS = 3'd3,
        IO_RXDATA = 3'd4
    } io_reg_e;

    // ------------------------------------------------------------------
    // Bus cycle decode
    // ------------------------------------------------------------------
    logic    w_rd;
    logic    w_wr;
    logic    w_both;
    logic    w_ram_hit;
    logic    w_io_hit;
    io_reg_e w_io_reg;

    // A cycle with both strobes is a protocol error: it neither reads nor writes.
    assign w_rd      = bus.re & ~bus.we;
    assign w_wr      = bus.we & ~bus.re;
    assign w_both    = bus.re & bus.we;
    assign w_ram_hit = ({1'b0, bus.addr} < RAM_LIMIT);
    assign w_io_hit  = !w_ram_hit && (bus.addr[15:3] == IO_BASE[15:3]);
    assign w_io_reg  = io_reg_e'(bus.addr[2:0]);

    // Per-target strobes. The RAM write is also gated by reset so that a write
    // in flight when reset is asserted never lands in the array.
    logic w_ram_we;
    logic w_led_we;
    logic w_cnt_clr;
    logic w_stat_we;
    logic w_pop;
    logic w_push;

    assign w_ram_we  = w_wr & w_ram_hit & reset_L;
    assign w_led_we  = w_wr & w_io_hit & (w_io_reg == IO_LED);
    assign w_cnt_clr = w_wr & w_io_hit & (w_io_reg == IO_CNT);
    assign w_stat_we = w_wr & w_io_hit & (w_io_reg == IO_STATUS);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [15:0]      r_ram [RAM_WORDS];
    logic [15:0]      r_led;
    logic [15:0]      r_sw_meta;
    logic [15:0]      r_sw_sync;
    logic [15:0]      r_cnt;
    logic             r_bus_err;
    logic [15:0]      r_fifo [FIFO_DEPTH];
    logic [FIFO_AW:0] r_wr_ptr;
    logic [FIFO_AW:0] r_rd_ptr;

    // Pointers carry one extra wrap bit: equal means empty, equal except for
    // the wrap bit means full.
    logic w_empty;
    logic w_full;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                     (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);

    // A pop is an RXDATA read of a non-empty FIFO; the push side sees the
    // occupancy from the start of the cycle, so a full FIFO refuses even when
    // a pop is happening on the same edge.
    assign w_pop  = w_rd & w_io_hit & (w_io_reg == IO_RXDATA) & ~w_empty;
    assign w_push = rx_valid & ~w_full;

    // RAM array: written on the edge that ends a write cycle.
    // NOTE: storage arrays have no reset; clearing them would need a reset
    // port on every word and the contents must survive reset anyway.
    always_ff @(posedge clock) begin
        if (w_ram_we) begin
            r_ram[bus.addr[RAM_AW-1:0]] <= bus.wdata;
        end
    end

    // Receive FIFO storage: written at the tail on every accepted push.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo[r_wr_ptr[FIFO_AW-1:0]] <= rx_data;
        end
    end

    // FIFO pointers: push and pop are independent, so doing both keeps occupancy.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            // NOTE: sequential state always uses non-blocking assignments so
            // every flop samples the values from before the edge.
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // LED output register.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            r_led <= '0;
        end else if (w_led_we) begin
            r_led <= bus.wdata;
        end
    end

    // Two-flop synchronizer for the asynchronous switch inputs.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
        end else begin
            r_sw_meta <= sw_in;
            r_sw_sync <= r_sw_meta;
        end
    end

    // Free-running cycle counter; any write to it restarts it from zero.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            r_cnt <= '0;
        end else if (w_cnt_clr) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Sticky protocol-error flag; a new error takes priority over a W1C clear.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            r_bus_err <= 1'b0;
        end else if (w_both) begin
            r_bus_err <= 1'b1;
        end else if (w_stat_we && bus.wdata[2]) begin
            r_bus_err <= 1'b0;
        end
    end

    // Combinational read mux; everything that is not a clean read returns zero.
    always_comb begin
        // NOTE: default first so every path assigns rdata and no latch is inferred.
        bus.rdata = '0;
        if (w_rd) begin
            if (w_ram_hit) begin
                bus.rdata = r_ram[bus.addr[RAM_AW-1:0]];
            end else if (w_io_hit) begin
                case (w_io_reg)
                    IO_LED:    bus.rdata = r_led;
                    IO_SW:     bus.rdata = r_sw_sync;
                    IO_CNT:    bus.rdata = r_cnt;
                    IO_STATUS: bus.rdata = {13'b0, r_bus_err, w_full, ~w_empty};
                    IO_RXDATA: bus.rdata = w_empty ? 16'h0000 : r_fifo[r_rd_ptr[FIFO_AW-1:0]];
                    default:   bus.rdata = '0;
                endcase
            end
        end
    end

    assign led_out  = r_led;
    assign rx_ready = ~w_full;
    assign bus_err  = r_bus_err;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: RAM, LED/SW, counter, receive FIFO,
// error flag and reset behaviour, each against hand-computed values.
`timescale 1ns/1ps

module tb_mem_bus_responder;

    logic        clock = 1'b0;
    logic        reset_L = 1'b0;
    logic [15:0] led_out;
    logic [15:0] sw_in;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        bus_err;

    int n_checks = 0;
    int n_errors = 0;

    mem_bus_responder_if bus_if ();

    mem_bus_responder #(
        .RAM_WORDS (1024),
        .IO_BASE   (16'hFF00),
        .FIFO_DEPTH(4)
    ) dut (
        .clock   (clock),
        .reset_L (reset_L),
        .bus     (bus_if.slave),
        .led_out (led_out),
        .sw_in   (sw_in),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .bus_err (bus_err)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    always #5 clock = ~clock;

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One write cycle: strobes set at the falling edge, committed at the next rising edge.
    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        @(negedge clock);
        bus_if.addr  = a;
        bus_if.wdata = d;
        bus_if.re    = 1'b0;
        bus_if.we    = 1'b1;
        @(posedge clock);
        #1;
        bus_if.we    = 1'b0;
    endtask

    // One read cycle: rdata checked mid-cycle, side effects land on the rising edge.
    task automatic bus_read(input logic [15:0] a, input string tag, input logic [15:0] exp);
        @(negedge clock);
        bus_if.addr = a;
        bus_if.re   = 1'b1;
        bus_if.we   = 1'b0;
        #1;
        check(tag, bus_if.rdata, exp);
        @(posedge clock);
        #1;
        bus_if.re   = 1'b0;
    endtask

    // Offer one word to the FIFO for exactly one clock edge.
    task automatic push_word(input logic [15:0] d);
        @(negedge clock);
        rx_valid = 1'b1;
        rx_data  = d;
        @(posedge clock);
        #1;
        rx_valid = 1'b0;
    endtask

    // Protocol-error cycle: both strobes for one edge.
    task automatic bus_both(input logic [15:0] a, input logic [15:0] d);
        @(negedge clock);
        bus_if.addr  = a;
        bus_if.wdata = d;
        bus_if.re    = 1'b1;
        bus_if.we    = 1'b1;
        #1;
        check("both_rdata", bus_if.rdata, 16'h0000);
        @(posedge clock);
        #1;
        bus_if.re    = 1'b0;
        bus_if.we    = 1'b0;
    endtask

    // Hard stop in case the sequence never reaches its end.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus_if.addr  = 16'h0000;
        bus_if.wdata = 16'h0000;
        bus_if.re    = 1'b0;
        bus_if.we    = 1'b0;
        sw_in        = 16'h0000;
        rx_data      = 16'h0000;
        rx_valid     = 1'b0;

        // Reset state, then release between edges.
        @(negedge clock);
        #1;
        check("rst_led",      led_out, 16'h0000);
        check("rst_rx_ready", {15'b0, rx_ready}, 16'h0001);
        check("rst_bus_err",  {15'b0, bus_err}, 16'h0000);
        check("rst_rdata",    bus_if.rdata, 16'h0000);
        reset_L = 1'b1;

        // Counter counts one per edge from reset release.
        repeat (10) @(posedge clock);
        bus_read(16'hFF02, "cnt_10", 16'd10);

        // RAM write/read, top RAM word, first address past RAM.
        bus_write(16'h0010, 16'hBEEF);
        bus_read (16'h0010, "ram_0010", 16'hBEEF);
        bus_write(16'h03FF, 16'h1234);
        bus_read (16'h03FF, "ram_03ff", 16'h1234);
        bus_write(16'h0400, 16'h5555);
        bus_read (16'h0400, "unmapped_0400", 16'h0000);

        // LED register, plus an unmapped I/O word that must not raise an error.
        bus_write(16'hFF00, 16'h00A5);
        check("led_out", led_out, 16'h00A5);
        bus_read (16'hFF00, "led_rd", 16'h00A5);
        bus_write(16'hFF05, 16'hFFFF);
        bus_read (16'hFF05, "unmapped_ff05", 16'h0000);
        check("no_err_unmapped", {15'b0, bus_err}, 16'h0000);

        // Switch synchronizer: new value visible only after the second edge.
        @(negedge clock);
        sw_in       = 16'h1234;
        bus_if.addr = 16'hFF01;
        bus_if.re   = 1'b1;
        #1;
        check("sw_before", bus_if.rdata, 16'h0000);
        @(posedge clock);
        #1;
        check("sw_edge1", bus_if.rdata, 16'h0000);
        @(posedge clock);
        #1;
        check("sw_edge2", bus_if.rdata, 16'h1234);
        bus_if.re = 1'b0;

        // Counter clear: reads 0 then 1 on the following cycles.
        bus_write(16'hFF02, 16'h1234);
        bus_read (16'hFF02, "cnt_clr0", 16'h0000);
        bus_read (16'hFF02, "cnt_clr1", 16'h0001);

        // FIFO fill: ready drops after four pushes, word 5 held at the source.
        bus_read(16'hFF03, "stat_empty", 16'h0000);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock);
            rx_valid = 1'b1;
            rx_data  = 16'(k);
            #1;
            check($sformatf("rx_ready_%0d", k), {15'b0, rx_ready}, (k <= 4) ? 16'h0001 : 16'h0000);
        end
        bus_read(16'hFF03, "stat_full", 16'h0003);
        bus_read(16'hFF04, "pop_1", 16'h0001);
        check("ready_after_pop", {15'b0, rx_ready}, 16'h0001);
        bus_read(16'hFF04, "pop_2", 16'h0002);
        rx_valid = 1'b0;
        bus_read(16'hFF04, "pop_3", 16'h0003);
        bus_read(16'hFF04, "pop_4", 16'h0004);
        bus_read(16'hFF04, "pop_5", 16'h0005);
        bus_read(16'hFF04, "pop_empty", 16'h0000);
        bus_read(16'hFF03, "stat_drained", 16'h0000);

        // Simultaneous push and pop at occupancy 2.
        push_word(16'h00A1);
        push_word(16'h00A2);
        @(negedge clock);
        rx_valid    = 1'b1;
        rx_data     = 16'h00A3;
        bus_if.addr = 16'hFF04;
        bus_if.re   = 1'b1;
        #1;
        check("pushpop_head", bus_if.rdata, 16'h00A1);
        @(posedge clock);
        #1;
        rx_valid  = 1'b0;
        bus_if.re = 1'b0;
        bus_read(16'hFF03, "stat_occ2", 16'h0001);
        bus_read(16'hFF04, "pushpop_a2", 16'h00A2);
        bus_read(16'hFF04, "pushpop_a3", 16'h00A3);
        bus_read(16'hFF04, "pushpop_empty", 16'h0000);

        // Push into an empty FIFO while reading it: read sees 0, word is kept.
        @(negedge clock);
        rx_valid    = 1'b1;
        rx_data     = 16'h0077;
        bus_if.addr = 16'hFF04;
        bus_if.re   = 1'b1;
        #1;
        check("empty_push_rd", bus_if.rdata, 16'h0000);
        @(posedge clock);
        #1;
        rx_valid  = 1'b0;
        bus_if.re = 1'b0;
        bus_read(16'hFF04, "empty_push_kept", 16'h0077);

        // Error path: no RAM write, sticky flag, W1C clear, error beats clear.
        bus_both(16'h0010, 16'hDEAD);
        check("bus_err_set", {15'b0, bus_err}, 16'h0001);
        bus_read (16'h0010, "ram_unchanged", 16'hBEEF);
        bus_read (16'hFF03, "stat_err", 16'h0004);
        bus_write(16'hFF03, 16'h0003);
        check("bus_err_w0_kept", {15'b0, bus_err}, 16'h0001);
        bus_write(16'hFF03, 16'h0004);
        check("bus_err_clr", {15'b0, bus_err}, 16'h0000);
        bus_both(16'hFF03, 16'h0004);
        check("err_beats_clr", {15'b0, bus_err}, 16'h0001);

        // Reset in the middle of a write, with a word in the FIFO.
        push_word(16'h0055);
        @(negedge clock);
        bus_if.addr  = 16'hFF00;
        bus_if.wdata = 16'h5A5A;
        bus_if.we    = 1'b1;
        #2;
        reset_L = 1'b0;
        #1;
        check("rst_mid_led",   led_out, 16'h0000);
        check("rst_mid_ready", {15'b0, rx_ready}, 16'h0001);
        check("rst_mid_err",   {15'b0, bus_err}, 16'h0000);
        bus_if.addr  = 16'h0010;
        bus_if.wdata = 16'h1111;
        @(posedge clock);
        #1;
        bus_if.we   = 1'b0;
        bus_if.re   = 1'b1;
        bus_if.addr = 16'hFF03;
        #1;
        check("rst_mid_stat", bus_if.rdata, 16'h0000);
        @(negedge clock);
        bus_if.re = 1'b0;
        reset_L   = 1'b1;
        bus_read(16'h0010, "ram_kept", 16'hBEEF);
        bus_read(16'hFF04, "rx_flushed", 16'h0000);
        check("led_after_rst", led_out, 16'h0000);

        // Counter wrap FFFF -> 0000.
        bus_write(16'hFF02, 16'h0000);
        repeat (65535) @(posedge clock);
        bus_read(16'hFF02, "cnt_ffff", 16'hFFFF);
        bus_read(16'hFF02, "cnt_wrap", 16'h0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
- Memory-side responder for the p18240 memory bus, the slave end of the controlpath's MAR/MDR/RE/WE transactions.
- Decodes each bus cycle into one of two targets:
  - a word-addressed RAM;
  - a small memory-mapped I/O page: LED output register, synchronized switch input, free-running cycle counter, status register, and a receive FIFO fed by an external byte/word source.
- Sits between the datapath's MAR/MDR and the board; replaces a bare RAM in the top level.

Parameters:
- RAM_WORDS, 1024, number of 16-bit RAM words at addresses 0..RAM_WORDS-1 (power of 2, at most 32768).
- IO_BASE, 16'hFF00, base address of the I/O page (8 words, IO_BASE..IO_BASE+7).
- FIFO_DEPTH, 4, receive FIFO entries (power of 2, at least 2).

Ports:
- clock  input  1  system clock, all state changes on its rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- addr  input  16  word address (MAR).
- wdata  input  16  write data (MDR).
- re  input  1  memory read request for this cycle.
- we  input  1  memory write request for this cycle.
- rdata  output  16  read data, combinational, valid while re=1.
- led_out  output  16  LED register contents.
- sw_in  input  16  asynchronous switch inputs.
- rx_data  input  16  receive source data word.
- rx_valid  input  1  receive source has a word.
- rx_ready  output  1  FIFO can accept a word (=!full).
- bus_err  output  1  sticky protocol-error flag.

Behaviour:
- Reset (reset_L=0, asynchronous):
  - led_out=0, counter=0, FIFO empty (rx_ready=1), bus_err=0, switch synchronizer flops=0.
  - RAM contents are not reset.
- Read timing:
  - re=1, we=0: rdata is combinational from addr in the same cycle, so MDR captures it at the edge ending the RE cycle.
  - Read side effects (FIFO pop) take effect on that same edge.
  - re=0: rdata=16'h0000.
- Write: we=1, re=0 commits wdata to the decoded target on the rising edge.
- re=1 and we=1 in the same cycle:
  - no read side effect, no write; rdata=0;
  - bus_err set on that edge and held until cleared.
- Address map:
  - addr<RAM_WORDS: RAM read/write.
  - IO_BASE+0 LED: R/W; write loads led_out.
  - IO_BASE+1 SW: read-only. sw_in passes through a 2-flop synchronizer; a read returns the second flop. Writes ignored.
  - IO_BASE+2 CNT: 16-bit counter, increments every cycle, wraps FFFF->0000. Read returns the current value. A write of any data loads 0 on that edge; the counter reads 0 in the next cycle and 1 the cycle after.
  - IO_BASE+3 STATUS: read = {13'b0, bus_err, full, !empty}. Write: wdata[2]=1 clears bus_err (W1C); other bits ignored. A simultaneous re&we error wins over the clear.
  - IO_BASE+4 RXDATA: a read returns the FIFO head and pops it on the edge. A read while empty returns 0 with no pop and no error. Writes ignored.
  - IO_BASE+5..+7 and any other unmapped address: read 0, write ignored, no error.
- Receive FIFO:
  - Circular buffer, FIFO_DEPTH entries; pointers one bit wider than the index for full/empty.
  - Push when rx_valid&&rx_ready on the edge; rx_ready=!full, combinational from occupancy.
  - Push and pop in the same cycle: both occur and occupancy is unchanged.
  - When full: rx_ready=0, so no push; a pop in that cycle frees a slot, and rx_ready=1 the next cycle.
  - When empty, a push and an RXDATA read in the same cycle: the read returns 0 and the word is stored.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset asserted mid-transaction: an in-flight write is dropped, the FIFO is flushed, and RAM keeps prior contents.

Test Plan:
1. RAM: write 16'hBEEF to addr 16'h0010, then read 16'h0010 -> rdata=16'hBEEF during the re cycle. Read 16'h0400 (RAM_WORDS=1024, unmapped) -> rdata=0.
2. LED/SW: write 16'h00A5 to FF00 -> led_out=16'h00A5 the next cycle. Set sw_in=16'h1234 -> a read of FF01 returns 16'h1234 only from the 2nd edge after the change, and the old value before that.
3. Counter:
   - 10 cycles after reset, read FF02 -> 16'd10.
   - Write FF02 -> reads 0 then 1 on the following cycles.
   - Force to FFFF via cycles -> wraps to 0000.
4. FIFO:
   - Push 5 words 1..5 with rx_valid held -> rx_ready=0 after 4 pushes; word 5 is held at the source.
   - Status read = 16'h0003.
   - Four FF04 reads return 1,2,3,4; word 5 is accepted after the first pop.
   - A read while empty returns 0.
5. Simultaneous push+pop at occupancy 2 -> occupancy stays 2 and data order is preserved.
6. Error path:
   - re=we=1 at addr 0x0010 -> RAM unchanged, bus_err=1, status bit2=1.
   - Write FF03 with 16'h0004 -> bus_err=0.
   - Assert reset_L=0 mid-write -> led_out=0 and the FIFO empty immediately.
